// File: rtl/dfr_output_streamer.sv
// Streams dfr_output_mem contents to an AXI4-Stream master through a small prefetch FIFO.
// Optional build macro DFR_STREAM_CLASSIFY_EN replaces each word with its (word >= threshold) class bit.
module dfr_output_streamer #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_samples,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_tx_cnt;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_inflight;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_hs;
    logic [CW:0]           w_occupancy;
    logic [DATA_WIDTH-1:0] w_push_data;

`ifdef DFR_STREAM_CLASSIFY_EN
    assign w_push_data = {{(DATA_WIDTH-1){1'b0}}, ($signed(mem_dout) >= $signed(threshold))};
`else
    logic w_unused_threshold;
    assign w_unused_threshold = ^threshold;
    assign w_push_data        = mem_dout;
`endif

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_occupancy = {1'b0, r_count} + (CW+1)'(r_inflight);
    // Reads in flight count against FIFO space so the write a cycle later always fits.
    assign w_issue     = (r_state == ST_RUN) && (r_rd_cnt < r_num)
                         && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign w_push      = r_inflight;
    assign w_pop       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_last_hs   = w_pop && M_AXIS_TLAST;

    assign mem_rd_en     = w_issue;
    assign mem_addr      = w_issue ? r_rd_cnt : r_last_addr;
    assign M_AXIS_TVALID = (r_count != '0);
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? r_fifo[r_rd_ptr] : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (r_tx_cnt == (r_num - ADDR_WIDTH'(1)));
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_FIN);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_samples != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (w_last_hs) begin
                    w_state_next = ST_FIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_num       <= '0;
            r_rd_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_last_addr <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_last_addr <= r_rd_cnt;
            end
            if (w_accept) begin
                r_num    <= num_samples;
                r_rd_cnt <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
                end
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: the empty count hides stale entries.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_dfr_output_streamer.sv
// Self-checking bench for dfr_output_streamer: directed runs plus a per-cycle stream/read-rule model.
// Build with DFR_STREAM_CLASSIFY_EN defined to exercise the classify variant.
module tb_dfr_output_streamer;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    logic                  clock;
    logic                  aresetN;
    logic                  start;
    logic [ADDR_WIDTH-1:0] numSamples;
    logic [DATA_WIDTH-1:0] threshold;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memRdEn;
    logic [DATA_WIDTH-1:0] memDout;
    logic [DATA_WIDTH-1:0] tData;
    logic                  tValid;
    logic                  tReady;
    logic                  tLast;

    logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] capt [0:15];
    logic [31:0] exp6 [0:3];
    int          totalChecks = 0;
    int          badChecks   = 0;

    dfr_output_streamer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .S_AXI_ACLK   (clock),
        .S_AXI_ARESETN(aresetN),
        .start        (start),
        .num_samples  (numSamples),
        .threshold    (threshold),
        .busy         (busy),
        .done         (done),
        .mem_addr     (memAddr),
        .mem_rd_en    (memRdEn),
        .mem_dout     (memDout),
        .M_AXIS_TDATA (tData),
        .M_AXIS_TVALID(tValid),
        .M_AXIS_TREADY(tReady),
        .M_AXIS_TLAST (tLast)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (memRdEn) memDout <= ram[memAddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expWord(input int i);
`ifdef DFR_STREAM_CLASSIFY_EN
        return {31'b0, ($signed(ram[i]) >= $signed(threshold))};
`else
        return ram[i];
`endif
    endfunction

    // Model: beat i carries word i of the RAM, reads go out in address order and never
    // leave more than FIFO_DEPTH words issued but not yet handed over.
    task automatic compareLoop();
        int          mExpN = 0;
        int          mBeat = 0;
        int          mIssued = 0;
        int          mPopped = 0;
        logic [31:0] mLastAddr = 0;
        logic [31:0] mPrevData = 0;
        bit          mStallPrev = 0;
        forever begin
            @(negedge clock);
            if (!aresetN) begin
                mBeat = 0; mIssued = 0; mPopped = 0; mLastAddr = 0; mStallPrev = 0;
            end else begin
                if (start && !busy) begin
                    mExpN = int'(numSamples);
                    mBeat = 0; mIssued = 0; mPopped = 0; mStallPrev = 0;
                end
                if (memRdEn) begin
                    checkOutput("rd_addr", 32'(memAddr), mIssued);
                    checkOutput("rd_room", 32'((mIssued - mPopped) < FIFO_DEPTH), 1);
                    checkOutput("rd_limit", 32'(mIssued < mExpN), 1);
                    mIssued++;
                    mLastAddr = 32'(memAddr);
                end else begin
                    checkOutput("addr_hold", 32'(memAddr), mLastAddr);
                end
                if (mStallPrev) checkOutput("valid_hold", 32'(tValid), 1);
                if (tValid) begin
                    checkOutput("tdata", tData, expWord(mBeat));
                    checkOutput("tlast", 32'(tLast), 32'(mBeat == mExpN - 1));
                    if (mStallPrev) checkOutput("tdata_stable", tData, mPrevData);
                    mStallPrev = !tReady;
                    mPrevData  = tData;
                    if (tReady) begin
                        mBeat++;
                        mPopped++;
                    end
                end else begin
                    checkOutput("tlast_idle", 32'(tLast), 0);
                    mStallPrev = 0;
                end
            end
        end
    endtask

    // One run: start accepted at edge 0, k counts the cycles after it.
    task automatic applyStimulus(input string tag, input int n, input logic [31:0] pat,
                                 input int midAt, input int midN, output int doneIdx);
        int firstValid = -1;
        int beats = 0;
        int reads = 0;
        int doneCnt = 0;
        int lastHs = -1;
        int busyBad = 0;
        bit ended = 0;
        doneIdx = -1;
        @(posedge clock); #1;
        start = 1'b1;
        numSamples = ADDR_WIDTH'(n);
        @(posedge clock); #1;
        start = 1'b0;
        numSamples = '1;
        for (int k = 0; k < 200; k++) begin
            tReady = (k < 32) ? pat[k] : 1'b1;
            if (k == midAt) begin
                start = 1'b1;
                numSamples = ADDR_WIDTH'(midN);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (doneIdx >= 0) begin
                checkOutput({tag, "_busy_after"}, 32'(busy), 0);
                checkOutput({tag, "_done_after"}, 32'(done), 0);
                ended = 1;
                break;
            end
            if (!busy) busyBad++;
            if (memRdEn) reads++;
            if (tValid && firstValid < 0) firstValid = k;
            if (tValid && tReady) begin
                if (beats < 16) capt[beats] = tData;
                beats++;
                lastHs = k;
            end
            if (done) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = k;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        checkOutput({tag, "_ended"}, 32'(ended), 1);
        checkOutput({tag, "_beats"}, beats, n);
        checkOutput({tag, "_reads"}, reads, n);
        checkOutput({tag, "_done_count"}, doneCnt, 1);
        checkOutput({tag, "_busy_gap"}, busyBad, 0);
        if (n > 0) begin
            checkOutput({tag, "_first_valid"}, firstValid, 2);
            checkOutput({tag, "_done_idx"}, doneIdx, lastHs + 1);
        end else begin
            checkOutput({tag, "_first_valid"}, firstValid, -1);
            checkOutput({tag, "_done_idx"}, doneIdx, 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_tvalid"}, 32'(tValid), 0);
        checkOutput({tag, "_tlast"}, 32'(tLast), 0);
        checkOutput({tag, "_tdata"}, tData, 0);
        checkOutput({tag, "_rd_en"}, 32'(memRdEn), 0);
        checkOutput({tag, "_addr"}, 32'(memAddr), 0);
    endtask

    initial begin
        int          idx;
        int          hs;
        logic [31:0] pat;
        aresetN    = 1'b0;
        start      = 1'b0;
        numSamples = '0;
        threshold  = '0;
        tReady     = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 32'(10 + i);
        fork
            compareLoop();
        join_none

        repeat (2) @(posedge clock);
        #1 checkAllZero("reset");
        @(posedge clock); #1 aresetN = 1'b1;

        $display("[TB] run 1: N=5, ready held high");
        applyStimulus("t1", 5, '1, -1, 0, idx);
        checkOutput("t1_done_at_7", idx, 7);
        for (int i = 0; i < 5; i++) checkOutput("t1_word", capt[i], 32'(10 + i));

        $display("[TB] run 2: N=5, ready pattern 1,0,0,1 then random");
        pat = $urandom;
        pat[3:0] = 4'b1001;
        applyStimulus("t2", 5, pat, -1, 0, idx);
        for (int i = 0; i < 5; i++) checkOutput("t2_word", capt[i], 32'(10 + i));

        $display("[TB] run 3: N=0");
        applyStimulus("t3", 0, '1, -1, 0, idx);

        $display("[TB] run 4: N=5 with ignored start N=3 mid-run");
        applyStimulus("t4", 5, '1, 1, 3, idx);
        checkOutput("t4_done_at_7", idx, 7);
        for (int i = 0; i < 5; i++) checkOutput("t4_word", capt[i], 32'(10 + i));

        $display("[TB] run 5: reset after second beat of N=8");
        @(posedge clock); #1;
        start = 1'b1;
        numSamples = 14'd8;
        tReady = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        hs = 0;
        for (int k = 0; k < 20 && hs < 2; k++) begin
            @(negedge clock);
            if (tValid && tReady) hs++;
        end
        checkOutput("t5_two_beats", hs, 2);
        @(posedge clock); #1;
        aresetN = 1'b0;
        #1 checkAllZero("t5_midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("t5_no_done", 32'(done), 0);
        end
        @(posedge clock); #1 aresetN = 1'b1;
        applyStimulus("t5b", 2, '1, -1, 0, idx);
        checkOutput("t5b_word0", capt[0], 32'd10);
        checkOutput("t5b_word1", capt[1], 32'd11);

        $display("[TB] run 6: signed words against threshold 0");
        ram[0] = 32'hFFFF_FFFD;
        ram[1] = 32'h0000_0000;
        ram[2] = 32'h0000_0007;
        ram[3] = 32'h8000_0000;
`ifdef DFR_STREAM_CLASSIFY_EN
        exp6[0] = 32'd0; exp6[1] = 32'd1; exp6[2] = 32'd1; exp6[3] = 32'd0;
`else
        exp6[0] = 32'hFFFF_FFFD; exp6[1] = 32'd0; exp6[2] = 32'd7; exp6[3] = 32'h8000_0000;
`endif
        applyStimulus("t6", 4, '1, -1, 0, idx);
        for (int i = 0; i < 4; i++) checkOutput("t6_word", capt[i], exp6[i]);

        $display("[TB] test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
